// File: rtl/ctrl_seq_pkg.sv
// Shared CPU definitions: opcodes, sequencer states and control-bit indices.
// Used by the sequencer, the ALU/ACC block and the datapath.
package ctrl_seq_pkg;

  localparam int unsigned CTRL_W = 22;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_DIV    = 8'h09;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHR    = 8'h0D;
  localparam logic [7:0] OP_SHL    = 8'h0E;

  localparam int unsigned C_PC_MAR  = 0;
  localparam int unsigned C_MEM_RD  = 1;
  localparam int unsigned C_PC_INC  = 2;
  localparam int unsigned C_MBR_IR  = 3;
  localparam int unsigned C_IR_MAR  = 4;
  localparam int unsigned C_MBR_BR  = 5;
  localparam int unsigned C_ACC_MBR = 6;
  localparam int unsigned C_MEM_WR  = 7;
  localparam int unsigned C_ACC_CLR = 8;
  localparam int unsigned C_ADD     = 9;
  localparam int unsigned C_IR_PC   = 10;
  localparam int unsigned C_SUB     = 13;
  localparam int unsigned C_MUL     = 15;
  localparam int unsigned C_DIV     = 16;
  localparam int unsigned C_SHR     = 17;
  localparam int unsigned C_SHL     = 18;
  localparam int unsigned C_AND     = 19;
  localparam int unsigned C_OR      = 20;
  localparam int unsigned C_NOT     = 21;

  localparam logic [CTRL_W-1:0] M_PC_MAR  = CTRL_W'(1) << C_PC_MAR;
  localparam logic [CTRL_W-1:0] M_MEM_RD  = CTRL_W'(1) << C_MEM_RD;
  localparam logic [CTRL_W-1:0] M_PC_INC  = CTRL_W'(1) << C_PC_INC;
  localparam logic [CTRL_W-1:0] M_MBR_IR  = CTRL_W'(1) << C_MBR_IR;
  localparam logic [CTRL_W-1:0] M_IR_MAR  = CTRL_W'(1) << C_IR_MAR;
  localparam logic [CTRL_W-1:0] M_MBR_BR  = CTRL_W'(1) << C_MBR_BR;
  localparam logic [CTRL_W-1:0] M_ACC_MBR = CTRL_W'(1) << C_ACC_MBR;
  localparam logic [CTRL_W-1:0] M_MEM_WR  = CTRL_W'(1) << C_MEM_WR;
  localparam logic [CTRL_W-1:0] M_ACC_CLR = CTRL_W'(1) << C_ACC_CLR;
  localparam logic [CTRL_W-1:0] M_ADD     = CTRL_W'(1) << C_ADD;
  localparam logic [CTRL_W-1:0] M_IR_PC   = CTRL_W'(1) << C_IR_PC;
  localparam logic [CTRL_W-1:0] M_SUB     = CTRL_W'(1) << C_SUB;
  localparam logic [CTRL_W-1:0] M_MUL     = CTRL_W'(1) << C_MUL;
  localparam logic [CTRL_W-1:0] M_DIV     = CTRL_W'(1) << C_DIV;
  localparam logic [CTRL_W-1:0] M_SHR     = CTRL_W'(1) << C_SHR;
  localparam logic [CTRL_W-1:0] M_SHL     = CTRL_W'(1) << C_SHL;
  localparam logic [CTRL_W-1:0] M_AND     = CTRL_W'(1) << C_AND;
  localparam logic [CTRL_W-1:0] M_OR      = CTRL_W'(1) << C_OR;
  localparam logic [CTRL_W-1:0] M_NOT     = CTRL_W'(1) << C_NOT;

  typedef enum logic [3:0] {
    ST_IDLE, ST_F0, ST_F1, ST_F2, ST_DEC, ST_EADDR,
    ST_EMEM, ST_EST, ST_EBR, ST_EALU, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_MEM, CLS_STORE, CLS_REG, CLS_HALT
  } op_class_e;

  // Execute-path class of an opcode; anything undefined behaves as NOP.
  function automatic op_class_e op_class(input logic [7:0] op);
    case (op)
      OP_STORE:                     return CLS_STORE;
      OP_LOAD, OP_ADD, OP_SUB, OP_MPY,
      OP_DIV, OP_AND, OP_OR:        return CLS_MEM;
      OP_NOT, OP_SHR, OP_SHL,
      OP_JMP, OP_JMPGEZ:            return CLS_REG;
      OP_HALT:                      return CLS_HALT;
      default:                      return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Sequencer handshake bundle: run/opcode/flags/memory-ack in, control pulses out.
interface ctrl_seq_if;
  logic        run;
  logic [7:0]  ir_op;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic [21:0] ctrl;
  logic        halted;

  modport master (
    output run, ir_op, alu_flags, mem_ready,
    input  ctrl, halted
  );

  modport slave (
    input  run, ir_op, alu_flags, mem_ready,
    output ctrl, halted
  );
endinterface

// File: rtl/ctrl_seq_dec.sv
// Combinational control-word decode from sequencer state, opcode, sign flag
// and memory acknowledge.
module ctrl_seq_dec
  import ctrl_seq_pkg::*;
(
  input  state_e              state,
  input  logic [7:0]          ir_op,
  input  logic                sign,
  input  logic                mem_ready,
  output logic [CTRL_W-1:0]   ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_F0:    ctrl = M_PC_MAR;
      ST_F1:    ctrl = mem_ready ? (M_MEM_RD | M_PC_INC) : M_MEM_RD;
      ST_F2:    ctrl = M_MBR_IR;
      ST_EADDR: ctrl = (ir_op == OP_LOAD) ? (M_IR_MAR | M_ACC_CLR) : M_IR_MAR;
      ST_EMEM:  ctrl = (ir_op == OP_STORE) ? M_MEM_WR : M_MEM_RD;
      ST_EST:   ctrl = M_ACC_MBR;
      ST_EBR:   ctrl = M_MBR_BR;
      ST_EALU: begin
        case (ir_op)
          OP_LOAD, OP_ADD: ctrl = M_ADD;
          OP_SUB:          ctrl = M_SUB;
          OP_MPY:          ctrl = M_MUL;
          OP_DIV:          ctrl = M_DIV;
          OP_AND:          ctrl = M_AND;
          OP_OR:           ctrl = M_OR;
          OP_NOT:          ctrl = M_NOT;
          OP_SHR:          ctrl = M_SHR;
          OP_SHL:          ctrl = M_SHL;
          OP_JMP:          ctrl = M_IR_PC;
          OP_JMPGEZ:       ctrl = sign ? '0 : M_IR_PC;
          default:         ctrl = '0;
        endcase
      end
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Instruction sequencer: state register and next-state logic; control word
// comes from ctrl_seq_dec so it follows state and inputs without a register.
module ctrl_seq
  import ctrl_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  ctrl_seq_if.slave bus
);

  state_e state;
  state_e instr_end;
  logic   halted_q;
  logic   unused_flags;

  // Only the sign flag steers sequencing.
  assign unused_flags = ^bus.alu_flags[2:0];
  assign instr_end    = bus.run ? ST_F0 : ST_IDLE;
  assign bus.halted   = halted_q;

  ctrl_seq_dec u_dec (
    .state     (state),
    .ir_op     (bus.ir_op),
    .sign      (bus.alu_flags[3]),
    .mem_ready (bus.mem_ready),
    .ctrl      (bus.ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.run) state <= ST_F0;
        ST_F0:   state <= ST_F1;
        ST_F1:   if (bus.mem_ready) state <= ST_F2;
        ST_F2:   state <= ST_DEC;
        ST_DEC: begin
          case (op_class(bus.ir_op))
            CLS_MEM, CLS_STORE: state <= ST_EADDR;
            CLS_REG:            state <= ST_EALU;
            CLS_HALT: begin
              state    <= ST_HALT;
              halted_q <= 1'b1;
            end
            default:            state <= instr_end;
          endcase
        end
        ST_EADDR: state <= (op_class(bus.ir_op) == CLS_STORE) ? ST_EST : ST_EMEM;
        ST_EST:   state <= ST_EMEM;
        ST_EMEM: begin
          // Stores finish on the write ack; reads continue to the operand latch.
          if (bus.mem_ready)
            state <= (op_class(bus.ir_op) == CLS_STORE) ? instr_end : ST_EBR;
        end
        ST_EBR:  state <= ST_EALU;
        ST_EALU: state <= instr_end;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: vector table, directed corner sequences
// and random instruction streams against a per-instruction sequence model.
module tb_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n;
  ctrl_seq_if bus ();

  ctrl_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [21:0] eq[$];
  bit          mq[$];

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  fl;
    int          cycles;
    logic [21:0] last;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [21:0] cb(input int n);
    return 22'd1 << n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic void add(input bit mr, input logic [21:0] c);
    eq.push_back(c);
    mq.push_back(mr);
  endfunction

  // Control word shown in the final execute cycle of each opcode.
  function automatic logic [21:0] op_bit(input logic [7:0] op, input logic [3:0] fl);
    case (op)
      8'h02, 8'h03: return cb(9);
      8'h04: return cb(13);
      8'h08: return cb(15);
      8'h09: return cb(16);
      8'h0A: return cb(19);
      8'h0B: return cb(20);
      8'h0C: return cb(21);
      8'h0D: return cb(17);
      8'h0E: return cb(18);
      8'h06: return cb(10);
      8'h05: return fl[3] ? 22'd0 : cb(10);
      default: return 22'd0;
    endcase
  endfunction

  // Whole-instruction expected sequence: per cycle, mem_ready to drive and ctrl expected.
  function automatic void build(input logic [7:0] op, input logic [3:0] fl,
                                input int wf, input int wm);
    eq.delete();
    mq.delete();
    add(rnd_bit(), cb(0));
    for (int i = 0; i < wf; i++) add(1'b0, cb(1));
    add(1'b1, cb(1) | cb(2));
    add(rnd_bit(), cb(3));
    add(rnd_bit(), 22'd0);
    if (op inside {8'h02, 8'h03, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B}) begin
      add(rnd_bit(), cb(4) | ((op == 8'h02) ? cb(8) : 22'd0));
      for (int i = 0; i < wm; i++) add(1'b0, cb(1));
      add(1'b1, cb(1));
      add(rnd_bit(), cb(5));
      add(rnd_bit(), op_bit(op, fl));
    end else if (op == 8'h01) begin
      add(rnd_bit(), cb(4));
      add(rnd_bit(), cb(6));
      for (int i = 0; i < wm; i++) add(1'b0, cb(7));
      add(1'b1, cb(7));
    end else if (op inside {8'h05, 8'h06, 8'h0C, 8'h0D, 8'h0E}) begin
      add(rnd_bit(), op_bit(op, fl));
    end
  endfunction

  // Entered while sampling an F0 cycle; leaves after sampling the instruction's last cycle.
  task automatic run_instr(input string tag, input logic [7:0] op, input logic [3:0] fl,
                           input int wf, input int wm);
    build(op, fl, wf, wm);
    for (int j = 0; j < eq.size(); j++) begin
      if (j > 0) begin
        @(negedge clk);
        bus.mem_ready = mq[j];
        #2;
      end else begin
        bus.ir_op     = op;
        bus.alu_flags = fl;
        bus.mem_ready = mq[j];
        #1;
      end
      chk(tag, 32'(bus.ctrl), 32'(eq[j]));
      chk({tag, "_halted"}, 32'(bus.halted), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [21:0] add_seq[9];
    logic [21:0] last;
    logic [7:0]  op;
    int          cyc;
    int          r;
    int          u;
    logic [7:0]  defined_ops[13];

    tbl[0]  = '{8'h03, 4'h0, 8, cb(9)};
    tbl[1]  = '{8'h04, 4'h0, 8, cb(13)};
    tbl[2]  = '{8'h02, 4'h0, 8, cb(9)};
    tbl[3]  = '{8'h08, 4'h0, 8, cb(15)};
    tbl[4]  = '{8'h09, 4'h0, 8, cb(16)};
    tbl[5]  = '{8'h0A, 4'h0, 8, cb(19)};
    tbl[6]  = '{8'h0B, 4'h0, 8, cb(20)};
    tbl[7]  = '{8'h01, 4'h0, 7, cb(7)};
    tbl[8]  = '{8'h0C, 4'h0, 5, cb(21)};
    tbl[9]  = '{8'h0D, 4'h0, 5, cb(17)};
    tbl[10] = '{8'h0E, 4'h0, 5, cb(18)};
    tbl[11] = '{8'h06, 4'h8, 5, cb(10)};
    tbl[12] = '{8'h05, 4'h0, 5, cb(10)};
    tbl[13] = '{8'h05, 4'h8, 5, 22'd0};
    tbl[14] = '{8'h00, 4'h0, 4, 22'd0};
    tbl[15] = '{8'h3F, 4'h0, 4, 22'd0};
    tbl[16] = '{8'hFF, 4'h7, 4, 22'd0};

    defined_ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08,
                    8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};

    bus.run = 1'b0; bus.ir_op = 8'h00; bus.alu_flags = 4'h0; bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", 32'(bus.ctrl), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      next_cycle();
      chk("idle_hold", 32'(bus.ctrl), 32'd0);
    end

    // ADD with zero-wait memory, exact control sequence.
    add_seq = '{cb(0), cb(1) | cb(2), cb(3), 22'd0, cb(4), cb(1), cb(5), cb(9), cb(0)};
    @(negedge clk);
    bus.run = 1'b1; bus.ir_op = 8'h03; bus.mem_ready = 1'b1;
    #2;
    chk("idle_before_run", 32'(bus.ctrl), 32'd0);
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      chk("add_seq", 32'(bus.ctrl), 32'(add_seq[i]));
    end

    // Per-opcode cycle count and final control word, back to back.
    for (int i = 0; i < 17; i++) begin
      bus.ir_op = tbl[i].op;
      bus.alu_flags = tbl[i].fl;
      bus.mem_ready = 1'b1;
      #1;
      chk("tbl_f0", 32'(bus.ctrl), 32'(cb(0)));
      cyc = 1;
      last = 22'd0;
      for (int k = 0; k < 20; k++) begin
        next_cycle();
        if (bus.ctrl == cb(0)) break;
        last = bus.ctrl;
        cyc++;
      end
      chk("tbl_cycles", 32'(cyc), 32'(tbl[i].cycles));
      chk("tbl_last", 32'(last), 32'(tbl[i].last));
    end

    run_instr("load_wait", 8'h02, 4'h0, 0, 3);
    next_cycle();
    run_instr("fetch_wait_add", 8'h03, 4'h0, 2, 1);
    next_cycle();

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 13) op = defined_ops[r];
      else begin
        u = int'($urandom_range(0, 241));
        op = (u == 0) ? 8'h00 : 8'(14 + u);
      end
      run_instr("rand", op, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      next_cycle();
    end

    // STORE, then an undefined opcode as NOP with run dropped at its end.
    run_instr("store", 8'h01, 4'h0, 0, 0);
    next_cycle();
    bus.ir_op = 8'h3F; bus.mem_ready = 1'b1;
    #1;
    chk("nop_f0", 32'(bus.ctrl), 32'(cb(0)));
    next_cycle(); chk("nop_f1", 32'(bus.ctrl), 32'(cb(1) | cb(2)));
    next_cycle(); chk("nop_f2", 32'(bus.ctrl), 32'(cb(3)));
    next_cycle(); chk("nop_dec", 32'(bus.ctrl), 32'd0);
    bus.run = 1'b0;
    repeat (3) begin
      next_cycle();
      chk("nop_to_idle", 32'(bus.ctrl), 32'd0);
    end

    // Asynchronous reset during a fetch wait.
    @(negedge clk);
    bus.run = 1'b1; bus.ir_op = 8'h03; bus.mem_ready = 1'b0;
    next_cycle(); chk("wait_f0", 32'(bus.ctrl), 32'(cb(0)));
    next_cycle(); chk("wait_f1a", 32'(bus.ctrl), 32'(cb(1)));
    next_cycle(); chk("wait_f1b", 32'(bus.ctrl), 32'(cb(1)));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'(bus.ctrl), 32'd0);
    chk("async_rst_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.run = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) begin
      next_cycle();
      chk("post_rst_idle", 32'(bus.ctrl), 32'd0);
    end
    @(negedge clk);
    bus.run = 1'b1;
    next_cycle();
    chk("first_f0_after_rst", 32'(bus.ctrl), 32'(cb(0)));

    // HALT: sticky with run held high, left only through reset.
    bus.ir_op = 8'h07;
    next_cycle(); chk("halt_f1", 32'(bus.ctrl), 32'(cb(1) | cb(2)));
    next_cycle(); chk("halt_f2", 32'(bus.ctrl), 32'(cb(3)));
    next_cycle(); chk("halt_dec", 32'(bus.ctrl), 32'd0);
    chk("halt_dec_halted", 32'(bus.halted), 32'd0);
    repeat (20) begin
      next_cycle();
      chk("halt_ctrl", 32'(bus.ctrl), 32'd0);
      chk("halt_flag", 32'(bus.halted), 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", 32'(bus.halted), 32'd0);
    chk("halt_rst_ctrl", 32'(bus.ctrl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.run = 1'b0;
    repeat (2) begin
      next_cycle();
      chk("halt_rst_idle", 32'(bus.ctrl), 32'd0);
      chk("halt_rst_idle_flag", 32'(bus.halted), 32'd0);
    end
    @(negedge clk);
    bus.run = 1'b1;
    next_cycle();
    chk("restart_after_halt", 32'(bus.ctrl), 32'(cb(0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 clk  input  1  sole clock; all state changes on the rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 run  input  1  start/continue execution; sampled only in IDLE and at instruction end.
REQ-004 ir_op  input  8  opcode field IR[15:8]; valid from the DECODE cycle onward.
REQ-005 alu_flags  input  4  ALU flags; bit 3 = sign (N).
REQ-006 mem_ready  input  1  memory acknowledge; combinational, sampled in MEM-access states.
REQ-007 ctrl  output  22  control pulses, bit n = Cn, at most one datapath transfer set per cycle.
REQ-008 halted  output  1  high while in HALT.

Function
REQ-009 C-bit map SHALL be: C0 PC->MAR, C1 mem read->MBR, C2 PC+1, C3 MBR->IR, C4 IR[7:0]->MAR, C5 MBR->BR, C6 ACC->MBR, C7 MBR->mem write, C8 ACC clear, C9 add, C10 IR[7:0]->PC, C13 sub, C15 mul, C16 div, C17 shr, C18 shl, C19 and, C20 or, C21 not; C11, C12 and C14 are always 0.
REQ-010 States SHALL be IDLE, F0, F1, F2, DEC, EADDR, EMEM, EST, EBR, EALU, HALT.
REQ-011 ctrl SHALL be decoded combinationally from the current state, ir_op, alu_flags and mem_ready (no output register).
REQ-012 IDLE: ctrl=0; go to F0 when run=1.
REQ-013 F0: assert C0; go to F1.
REQ-014 F1: assert C1 every cycle; assert C2 and go to F2 only in a cycle with mem_ready=1, otherwise stay in F1.
REQ-015 F2: assert C3; go to DEC. DEC: ctrl=0; branch on ir_op.
REQ-016 Opcodes SHALL be: 01 STORE, 02 LOAD, 03 ADD, 04 SUB, 05 JMPGEZ, 06 JMP, 07 HALT, 08 MPY, 09 DIV, 0A AND, 0B OR, 0C NOT, 0D SHR, 0E SHL.
REQ-017 Memory-operand ops (02-04, 08-0B) SHALL follow EADDR(C4) -> EMEM(C1, wait mem_ready) -> EBR(C5) -> EALU(one op bit).
REQ-018 LOAD SHALL assert C8 together with C4 in EADDR, then C9 in EALU.
REQ-019 STORE SHALL follow EADDR(C4) -> EST(C6) -> EMEM(C7, wait mem_ready) and then end the instruction.
REQ-020 NOT, SHR and SHL SHALL go DEC -> EALU asserting C21, C17 or C18 respectively.
REQ-021 JMP SHALL go DEC -> EALU asserting C10; JMPGEZ SHALL assert C10 only when alu_flags[3]=0, otherwise ctrl=0.
REQ-022 HALT opcode: DEC -> HALT; in HALT ctrl=0 and halted=1; HALT is left only by reset, and run is ignored.
REQ-023 Undefined opcodes (00, 0F-FF) SHALL act as NOP: DEC ends the instruction.
REQ-024 Instruction end SHALL go to F0 if run=1, else to IDLE.
REQ-025 Cycle counts with zero-wait memory SHALL be: ADD/SUB/LOAD/MPY/DIV/AND/OR = 8; STORE = 7; NOT/SHR/SHL/JMP/JMPGEZ = 5; NOP = 4. Each mem_ready=0 cycle adds one cycle.

Reset
REQ-026 rst_n=0 SHALL force state to IDLE, ctrl=0 and halted=0 immediately, independent of clk, including mid-instruction and mid-wait.
REQ-027 After rst_n deasserts, the first F0 SHALL occur on the first edge with run=1.

Structure
REQ-028 The opcode constants, state encodings and C-bit index constants SHALL live in the shared CPU definitions package/include used by the ALU/ACC and datapath blocks.
REQ-029 One sub-module, ctrl_seq_dec, SHALL hold the combinational state/opcode -> ctrl decode; ctrl_seq holds the state register and the next-state logic.

Verification
REQ-030 Reset then run=1, ir_op=03, mem_ready=1 -> ctrl sequence C0, C1|C2, C3, 0, C4, C1, C5, C9, then C0 again; 8 cycles total.
REQ-031 LOAD with mem_ready low for 3 cycles in EMEM -> C1 held for 4 cycles, EADDR shows C4|C8, and the final EALU cycle shows only C9.
REQ-032 JMPGEZ: alu_flags=4'b0000 -> C10 pulses in EALU; alu_flags=4'b1000 -> ctrl=0 in EALU; both take 5 cycles.
REQ-033 ir_op=07 -> halted=1 from the cycle after DEC, ctrl=0 for 20 cycles with run=1 held; rst_n pulse low -> halted=0 and state IDLE.
REQ-034 rst_n asserted low asynchronously mid-F1 wait -> ctrl=0 before the next clk edge; after release with run=0, IDLE is held.
REQ-035 ir_op=01 STORE, then ir_op=3F -> STORE shows C4, C6, C7 (7 cycles); 3F shows a 4-cycle NOP; run=0 at the end of the NOP -> IDLE.
